mem_port_arbiter: RTL

//   Shares one single-ported synchronous instruction/data memory between the CPU

---
 rtl/arb_pkg.sv | 31 +++
 rtl/rr_pick2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : arb_pkg
//  Purpose  : Shared types and limits for the I/D memory port arbiter and the
//             round-robin picker it uses.
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbiter control state: idle, or one transaction in flight.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Which CPU port owns the in-flight transaction.
    typedef enum logic [0:0] {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // Largest memory read latency the arbiter supports.
    localparam int MEM_LAT_MAX = 4;

    // True when a memory latency value is within the supported range.
    function automatic logic lat_legal(input int lat);
        return (lat >= 1) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational two-way round-robin pick. A lone requester wins;
//             when both request, the side that was not served last wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2
    import arb_pkg::*;
(
    input  logic     req_i,
    input  logic     req_d,
    input  arb_src_t last_src,
    output logic     gnt_i,
    output logic     gnt_d
);

    // Pick at most one winner; conflict is resolved against the last winner.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            if (last_src == SRC_I) begin
                gnt_d = 1'b1;
            end else begin
                gnt_i = 1'b1;
            end
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported synchronous memory between the CPU
//             fetch port (I) and load/store port (D). One transaction in
//             flight, round-robin on conflict, fixed read latency MEM_LAT.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
)(
    input  logic          clk,
    input  logic          clrn,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory port
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    // Counter just wide enough to reach MEM_LAT; guarded so an illegal
    // MEM_LAT still elaborates far enough to report the error below.
    localparam int                c_cnt_w = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_lat  = c_cnt_w'(MEM_LAT);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    generate
        if (!lat_legal(MEM_LAT)) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
        end
    endgenerate

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_next_count;
    arb_src_t            r_src;
    arb_src_t            r_last;
    logic                r_we;
    logic [DW-1:0]       r_i_rdata;
    logic [DW-1:0]       r_d_rdata;

    logic                w_complete;
    logic                w_slot;
    logic                w_pick_i;
    logic                w_pick_d;
    logic                w_gnt_i;
    logic                w_gnt_d;
    logic                w_issue;
    arb_src_t            w_issue_src;

    // The completion cycle doubles as an issue slot so back-to-back
    // transactions run at one per MEM_LAT cycles. Grants are held off while
    // reset is asserted because the slot itself is purely combinational.
    assign w_complete  = (r_state == ARB_BUSY) && (r_count == c_lat);
    assign w_slot      = clrn && ((r_state == ARB_IDLE) || w_complete);

    rr_pick2 u_pick (
        .req_i    (i_req),
        .req_d    (d_req),
        .last_src (r_last),
        .gnt_i    (w_pick_i),
        .gnt_d    (w_pick_d)
    );

    assign w_gnt_i     = w_slot && w_pick_i;
    assign w_gnt_d     = w_slot && w_pick_d;
    assign w_issue     = w_gnt_i || w_gnt_d;
    assign w_issue_src = w_gnt_d ? SRC_D : SRC_I;

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = w_complete && (r_src == SRC_I);
    assign d_rvalid = w_complete && (r_src == SRC_D);
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and latency counter: count restarts at 1 on every issue and
    // returns to 0 when the arbiter drops back to idle, so it never wraps.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            ARB_IDLE: begin
                if (w_issue) begin
                    w_next_state = ARB_BUSY;
                    w_next_count = c_one;
                end
            end
            ARB_BUSY: begin
                if (w_complete) begin
                    if (w_issue) begin
                        w_next_count = c_one;
                    end else begin
                        w_next_state = ARB_IDLE;
                        w_next_count = '0;
                    end
                end else begin
                    w_next_count = r_count + c_one;
                end
            end
        endcase
    end

    // Memory command mux: driven from the granted port, zero when idle.
    always_comb begin
        m_en    = w_issue;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_gnt_i) begin
            m_addr  = i_addr;
        end else if (w_gnt_d) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Transaction context captured at issue; r_last steers the next conflict.
    // D side is favoured out of reset by recording I as the last winner.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
            r_src   <= SRC_I;
            r_we    <= 1'b0;
            r_last  <= SRC_I;
        end else begin
            r_count <= w_next_count;
            if (w_issue) begin
                r_src  <= w_issue_src;
                r_we   <= w_gnt_d && d_we;
                r_last <= w_issue_src;
            end
        end
    end

    // Response data capture; a store completion leaves d_rdata untouched.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_complete) begin
            if (r_src == SRC_I) begin
                r_i_rdata <= m_rdata;
            end else if (!r_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

endmodule
`default_nettype wire
